// File: rtl/axis_byte_framer_if.sv
// AXI-Stream style interface used between the byte framer and its downstream
// stage. The master drives the payload and handshake-valid, the slaver drives
// ready. aclk/aresetn travel with the bundle for stages that want them.
interface axi_stream_inf #(
  parameter int DSIZE = 8
) (
  input logic aclk,
  input logic aresetn
);

  logic               axis_tvalid;
  logic               axis_tready;
  logic [DSIZE-1:0]   axis_tdata;
  logic               axis_tlast;
  logic [DSIZE/8-1:0] axis_tkeep;
  logic               axis_tuser;

  modport master (
    input  aclk,
    input  aresetn,
    output axis_tvalid,
    output axis_tdata,
    output axis_tlast,
    output axis_tkeep,
    output axis_tuser,
    input  axis_tready
  );

  modport slaver (
    input  aclk,
    input  aresetn,
    input  axis_tvalid,
    input  axis_tdata,
    input  axis_tlast,
    input  axis_tkeep,
    input  axis_tuser,
    output axis_tready
  );

endinterface

// File: rtl/axis_byte_framer.sv
// Byte framer: a first-word-fall-through FIFO feeding an AXI-Stream master.
// Every FRAME_LEN transferred beats form one frame; the last beat carries
// tlast, and each completed frame pulses frame_done and bumps frame_cnt.
module axis_byte_framer #(
  parameter int FRAME_LEN = 16,
  parameter int DEPTH     = 16
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     frame_done,
  output logic [15:0]              frame_cnt,
  axi_stream_inf.master            axis_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [BW-1:0] LAST_BEAT  = BW'(FRAME_LEN - 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] beat_idx;
  logic          out_valid;
  logic          out_last;
  logic          push;
  logic          pop;

  // Handshake decode; everything here comes from registered state plus the
  // live valid/ready inputs, so no output depends on a same-cycle pop/push.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    out_valid = 1'b0;
    out_last  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    out_valid = (fifo_level != '0);
    out_last  = out_valid && (beat_idx == LAST_BEAT);
    push      = in_valid && in_ready;
    pop       = out_valid && axis_out.axis_tready;
  end

  assign in_ready             = (fifo_level < LEVEL_FULL);
  assign axis_out.axis_tvalid = out_valid;
  assign axis_out.axis_tdata  = mem[rd_ptr];
  assign axis_out.axis_tlast  = out_last;
  assign axis_out.axis_tkeep  = '1;
  assign axis_out.axis_tuser  = 1'b0;

  // FIFO storage write at the tail.
  // NOTE: the storage array has no reset; the pointers and level alone decide
  // which entries are meaningful, so clearing the array would buy nothing.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        fifo_level <= fifo_level + 1'b1;
      end else if (pop && !push) begin
        fifo_level <= fifo_level - 1'b1;
      end
    end
  end

  // Beat position within the frame, frame completion pulse and frame counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      beat_idx   <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_done <= pop && out_last;
      if (pop) begin
        if (out_last) begin
          beat_idx  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          beat_idx <= beat_idx + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis_byte_framer.sv
// Self-checking bench for axis_byte_framer. A negedge monitor keeps a queue of
// accepted bytes and a beat/frame model, and compares every transfer, stall,
// level and frame pulse against it. Directed sequences cover the main cases.
module tb_axis_byte_framer;

  localparam int DEPTH     = 16;
  localparam int FRAME_LEN = 16;

  logic        clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  fifo_level;
  logic        frame_done;
  logic [15:0] frame_cnt;

  always #5 clock = ~clock;

  axi_stream_inf #(.DSIZE(8)) axis_if (.aclk(clock), .aresetn(rst_n));

  axis_byte_framer #(
    .FRAME_LEN(FRAME_LEN),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .fifo_level(fifo_level),
    .frame_done(frame_done),
    .frame_cnt(frame_cnt),
    .axis_out(axis_if)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard / reference model, evaluated on the falling edge so every
  // input and output is settled ahead of the next rising edge.
  logic [7:0]  exp_q[$];
  int          exp_beat = 0;
  logic [15:0] exp_frames = 16'h0000;
  logic        prev_stall = 1'b0;
  logic        prev_last_xfer = 1'b0;
  logic [7:0]  prev_data = 8'h00;
  logic        prev_tlast = 1'b0;
  logic        preload = 1'b0;
  logic [7:0]  exp_byte;

  always @(negedge clock) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_beat       = 0;
      exp_frames     = 16'h0000;
      prev_stall     = 1'b0;
      prev_last_xfer = 1'b0;
    end else begin
      if (preload) exp_frames = 16'hFFFF;
      check("level", 32'(fifo_level), 32'(exp_q.size()));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
      check("tvalid", 32'(axis_if.axis_tvalid), 32'(exp_q.size() != 0));
      check("frame_done", 32'(frame_done), 32'(prev_last_xfer));
      check("frame_cnt", 32'(frame_cnt), 32'(exp_frames));
      if (prev_stall) begin
        check("stall_tvalid", 32'(axis_if.axis_tvalid), 32'd1);
        check("stall_tdata", 32'(axis_if.axis_tdata), 32'(prev_data));
        check("stall_tlast", 32'(axis_if.axis_tlast), 32'(prev_tlast));
      end
      prev_last_xfer = 1'b0;
      if (axis_if.axis_tvalid && axis_if.axis_tready && exp_q.size() != 0) begin
        exp_byte = exp_q.pop_front();
        check("tdata", 32'(axis_if.axis_tdata), 32'(exp_byte));
        check("tlast", 32'(axis_if.axis_tlast), 32'(exp_beat == FRAME_LEN - 1));
        if (exp_beat == FRAME_LEN - 1) begin
          exp_beat       = 0;
          exp_frames     = exp_frames + 16'd1;
          prev_last_xfer = 1'b1;
        end else begin
          exp_beat = exp_beat + 1;
        end
      end
      prev_stall = axis_if.axis_tvalid && !axis_if.axis_tready;
      prev_data  = axis_if.axis_tdata;
      prev_tlast = axis_if.axis_tlast;
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Offer one byte and hold it until the block accepts it (bounded).
  task automatic send(input logic [7:0] b);
    int n;
    n        = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    check("send_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for the FIFO to empty, optionally with a random ready pattern.
  task automatic drain(input bit rand_ready);
    int n;
    n = 0;
    while (fifo_level != 0 && n < 2000) begin
      axis_if.axis_tready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      tick();
      n++;
    end
    axis_if.axis_tready = 1'b1;
    check("drain_empty", 32'(fifo_level), 32'd0);
  endtask

  initial begin
    int          acc;
    int          sent;
    logic        ok;
    logic [7:0]  cur;

    axis_if.axis_tready = 1'b0;
    repeat (2) tick();

    // Reset state.
    check("rst_tvalid", 32'(axis_if.axis_tvalid), 32'd0);
    check("rst_tlast", 32'(axis_if.axis_tlast), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("tkeep", 32'(axis_if.axis_tkeep), 32'd1);
    check("tuser", 32'(axis_if.axis_tuser), 32'd0);
    rst_n = 1'b1;
    tick();

    // One full frame 0x00..0x0F, ready always high.
    axis_if.axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) send(8'(i));
    drain(1'b0);
    tick();
    check("frame1_cnt", 32'(frame_cnt), 32'd1);

    // Back-pressure: offer 20 bytes with ready low, only DEPTH fit.
    axis_if.axis_tready = 1'b0;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_data  = 8'(8'h20 + acc);
      in_valid = 1'b1;
      ok       = in_ready;
      tick();
      if (ok) acc++;
    end
    in_valid = 1'b0;
    check("full_accepted", 32'(acc), 32'd16);
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd16);
    axis_if.axis_tready = 1'b1;
    #1;
    check("full_ready_comb", 32'(in_ready), 32'd0);
    drain(1'b0);
    check("after_full_ready", 32'(in_ready), 32'd1);

    // Simultaneous push and pop at level 1.
    axis_if.axis_tready = 1'b0;
    send(8'hA5);
    check("pp_level_before", 32'(fifo_level), 32'd1);
    in_data  = 8'h5A;
    in_valid = 1'b1;
    axis_if.axis_tready = 1'b1;
    tick();
    in_valid = 1'b0;
    axis_if.axis_tready = 1'b0;
    check("pp_level", 32'(fifo_level), 32'd1);
    check("pp_head", 32'(axis_if.axis_tdata), 32'h5A);
    drain(1'b0);

    // Random valid/ready for 1000 bytes from a fresh reset.
    do_reset();
    sent = 0;
    cur  = 8'($urandom);
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      axis_if.axis_tready = ($urandom_range(0, 2) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = cur;
      ok       = in_valid && in_ready;
      tick();
      if (ok) begin
        sent++;
        cur = 8'($urandom);
      end
    end
    in_valid = 1'b0;
    check("rand_sent", 32'(sent), 32'd1000);
    drain(1'b1);
    tick();
    check("rand_frames", 32'(frame_cnt), 32'd62);

    // Reset in the middle of a frame.
    do_reset();
    axis_if.axis_tready = 1'b0;
    for (int i = 0; i < 10; i++) send(8'(8'h40 + i));
    axis_if.axis_tready = 1'b1;
    repeat (5) tick();
    check("mid_level", 32'(fifo_level), 32'd5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 32'(axis_if.axis_tvalid), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) send(8'(8'h60 + i));
    drain(1'b0);
    tick();
    check("mid_frames", 32'(frame_cnt), 32'd1);

    // Frame counter wrap from 0xFFFF.
    force dut.frame_cnt = 16'hFFFF;
    preload = 1'b1;
    #2;
    release dut.frame_cnt;
    tick();
    preload = 1'b0;
    check("preload_cnt", 32'(frame_cnt), 32'hFFFF);
    for (int i = 0; i < 16; i++) send(8'(8'h80 + i));
    drain(1'b0);
    tick();
    check("wrap_cnt", 32'(frame_cnt), 32'h0000);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
